// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer scan-out block.
package fb_pkg;

    localparam int unsigned H_PIXELS    = 128;
    localparam int unsigned V_LINES     = 128;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned ADDR_W      = 11;
    localparam int unsigned TOTAL_BYTES = H_PIXELS * V_LINES / DATA_W;

    typedef logic [ADDR_W-1:0] fb_addr_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } fb_state_e;

endpackage

// File: rtl/fb_scanout_if.sv
// Pixel stream with valid/ready handshake and frame/line markers.
interface fb_scanout_if;

    logic pix_valid;
    logic pix_ready;
    logic pix_data;
    logic pix_sof;
    logic pix_eol;

    modport master (
        output pix_valid,
        output pix_data,
        output pix_sof,
        output pix_eol,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        input  pix_sof,
        input  pix_eol,
        output pix_ready
    );

endinterface

// File: rtl/fb_byte_serializer.sv
// Byte-to-pixel serializer: MSB-first shift register, x/y pixel counters, SOF/EOL markers.
module fb_byte_serializer
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              pf_full_i,
    input  logic [DATA_W-1:0] pf_data_i,
    input  logic              invert_i,
    output logic              load_o,
    output logic              last_xfer_o,
    fb_scanout_if.master      pix_if
);

    localparam int unsigned XW = $clog2(H_PIXELS);
    localparam int unsigned YW = $clog2(V_LINES);
    localparam int unsigned CW = $clog2(DATA_W + 1);
    localparam logic [XW-1:0] XLast = XW'(H_PIXELS - 1);
    localparam logic [YW-1:0] YLast = YW'(V_LINES - 1);

    logic [DATA_W-1:0] sr_q, sr_d;
    logic [CW-1:0]     bcnt_q, bcnt_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic              valid;
    logic              xfer;

    assign valid  = (bcnt_q != '0);
    assign xfer   = valid && pix_if.pix_ready;
    // Reload on empty, or on the last bit's transfer so a full prefetch causes no bubble.
    assign load_o = pf_full_i && ((bcnt_q == '0) || (xfer && (bcnt_q == CW'(1))));

    assign pix_if.pix_valid = valid;
    assign pix_if.pix_data  = sr_q[DATA_W-1] ^ invert_i;
    assign pix_if.pix_sof   = valid && (x_q == '0) && (y_q == '0);
    assign pix_if.pix_eol   = valid && (x_q == XLast);
    assign last_xfer_o      = xfer && (x_q == XLast) && (y_q == YLast);

    // Next-state for shift register, bit count and pixel position.
    always_comb begin
        sr_d   = sr_q;
        bcnt_d = bcnt_q;
        x_d    = x_q;
        y_d    = y_q;
        if (load_o) begin
            sr_d   = pf_data_i;
            bcnt_d = CW'(DATA_W);
        end else if (xfer) begin
            sr_d   = sr_q << 1;
            bcnt_d = bcnt_q - CW'(1);
        end
        if (xfer) begin
            if (x_q == XLast) begin
                x_d = '0;
                y_d = (y_q == YLast) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
        if (clear_i) begin
            bcnt_d = '0;
            x_d    = '0;
            y_d    = '0;
        end
    end

    // Serializer state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q   <= '0;
            bcnt_q <= '0;
            x_q    <= '0;
            y_q    <= '0;
        end else begin
            sr_q   <= sr_d;
            bcnt_q <= bcnt_d;
            x_q    <= x_d;
            y_q    <= y_d;
        end
    end

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scan-out: walks BSRAM port B once per frame request and streams 1 bpp pixels.
// Optional macro FB_SCANOUT_INVERT_EN adds an invert_i port latched at frame start.
module fb_scanout
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
`ifdef FB_SCANOUT_INVERT_EN
    input  logic              invert_i,
`endif
    output fb_addr_t          fb_adb_o,
    output logic              fb_ceb_o,
    output logic              fb_oceb_o,
    output logic              fb_wreb_o,
    input  logic [DATA_W-1:0] fb_doutb_i,
    fb_scanout_if.master      pix_if,
    output logic              busy_o,
    output logic              frame_done_o
);

    localparam logic [ADDR_W:0] AddrEnd = (ADDR_W + 1)'(TOTAL_BYTES);

    fb_state_e         state_q, state_d;
    logic [ADDR_W:0]   addr_q, addr_d;
    fb_addr_t          adb_q, adb_d;
    logic [DATA_W-1:0] pf_q, pf_d;
    logic              pf_full_q, pf_full_d;
    logic              rd_pend_q, rd_pend_d;
    logic              start_acc;
    logic              issue;
    logic              sr_load;
    logic              last_xfer;
    logic              inv;

    assign start_acc = (state_q == StIdle) && start_i;
    // Single outstanding read; prefetch must be empty so the returning byte has a home.
    assign issue     = (state_q == StRun) && !pf_full_q && !rd_pend_q && (addr_q < AddrEnd);

`ifdef FB_SCANOUT_INVERT_EN
    logic invert_q;

    // Invert selection is frozen for the whole frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            invert_q <= 1'b0;
        end else if (start_acc) begin
            invert_q <= invert_i;
        end
    end

    assign inv = invert_q;
`else
    assign inv = 1'b0;
`endif

    // Frame sequencing: IDLE -> RUN on start, RUN -> DONE after the final transfer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StRun;
            StRun:   if (last_xfer) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Fetch engine next-state: address walk, held port-B address, prefetch capture.
    always_comb begin
        addr_d    = addr_q;
        adb_d     = adb_q;
        pf_d      = pf_q;
        pf_full_d = pf_full_q;
        rd_pend_d = issue;
        if (start_acc) begin
            addr_d = '0;
        end else if (issue) begin
            addr_d = addr_q + (ADDR_W + 1)'(1);
            adb_d  = addr_q[ADDR_W-1:0];
        end
        // Read data arrives one cycle after the strobe.
        if (rd_pend_q) begin
            pf_d      = fb_doutb_i;
            pf_full_d = 1'b1;
        end else if (sr_load) begin
            pf_full_d = 1'b0;
        end
    end

    // State and fetch registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            adb_q     <= '0;
            pf_q      <= '0;
            pf_full_q <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            adb_q     <= adb_d;
            pf_q      <= pf_d;
            pf_full_q <= pf_full_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    assign fb_ceb_o     = issue;
    assign fb_adb_o     = adb_d;
    assign fb_oceb_o    = 1'b1;
    assign fb_wreb_o    = 1'b0;
    assign busy_o       = (state_q != StIdle);
    assign frame_done_o = (state_q == StDone);

    fb_byte_serializer u_ser (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (start_acc),
        .pf_full_i   (pf_full_q),
        .pf_data_i   (pf_q),
        .invert_i    (inv),
        .load_o      (sr_load),
        .last_xfer_o (last_xfer),
        .pix_if      (pix_if)
    );

endmodule

// File: tb/tb_fb_scanout.sv
// Self-checking bench for fb_scanout: BSRAM model, expected-pixel scoreboard, handshake monitor.
module tb_fb_scanout;
    import fb_pkg::*;

    localparam int unsigned NPix = H_PIXELS * V_LINES;
`ifdef FB_SCANOUT_INVERT_EN
    localparam bit Inv = 1'b1;
`else
    localparam bit Inv = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
`ifdef FB_SCANOUT_INVERT_EN
    logic              invert = 1'b0;
`endif
    fb_addr_t          fb_adb;
    logic              fb_ceb, fb_oceb, fb_wreb;
    logic [DATA_W-1:0] fb_doutb;
    logic              busy, frame_done;

    fb_scanout_if pix_if ();

    fb_scanout u_dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start),
`ifdef FB_SCANOUT_INVERT_EN
        .invert_i     (invert),
`endif
        .fb_adb_o     (fb_adb),
        .fb_ceb_o     (fb_ceb),
        .fb_oceb_o    (fb_oceb),
        .fb_wreb_o    (fb_wreb),
        .fb_doutb_i   (fb_doutb),
        .pix_if       (pix_if),
        .busy_o       (busy),
        .frame_done_o (frame_done)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [TOTAL_BYTES];

    // BSRAM port B: registered read, data one cycle after the strobe.
    always @(posedge clk) begin
        if (fb_ceb) fb_doutb <= mem[fb_adb];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [2:0] exp_q [$];
    bit         rdy_rand = 1'b0;
    bit         mon_en = 1'b0;
    int         xfer_cnt, eol_cnt, rd_cnt, done_cnt, exp_addr;
    int         done_any = 0;
    bit         prev_stall, prev_ceb, prev_xfer;
    logic [2:0] prev_out;

    // Consumer ready: always high, or ~30% duty, updated just after each edge.
    initial begin
        pix_if.pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pix_if.pix_ready = rdy_rand ? ($urandom_range(99) < 30) : 1'b1;
        end
    end

    // Expected stream {data, sof, eol} for a whole frame from the memory image.
    task automatic push_frame(input bit inv);
        for (int a = 0; a < TOTAL_BYTES; a++) begin
            for (int b = DATA_W - 1; b >= 0; b--) begin
                int p;
                int x;
                p = a * DATA_W + (DATA_W - 1 - b);
                x = p % H_PIXELS;
                exp_q.push_back({mem[a][b] ^ inv, p == 0, x == H_PIXELS - 1});
            end
        end
    endtask

    task automatic monitor();
        logic [2:0] e;
        forever begin
            @(negedge clk);
            if (frame_done) done_any++;
            if (!reset && mon_en) begin
                if (prev_stall)
                    check("stall_hold",
                          {pix_if.pix_valid, pix_if.pix_data, pix_if.pix_sof, pix_if.pix_eol},
                          {1'b1, prev_out});
                if (fb_ceb) begin
                    check("one_outstanding", prev_ceb, 0);
                    check("rd_addr", fb_adb, exp_addr);
                    exp_addr++;
                    rd_cnt++;
                end
                if (frame_done) begin
                    done_cnt++;
                    check("done_after_last_xfer", prev_xfer, 1);
                    check("done_xfer_count", xfer_cnt, NPix);
                end
                if (pix_if.pix_valid && pix_if.pix_ready) begin
                    check("xfer_within_frame", xfer_cnt < NPix, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("pixel", {pix_if.pix_data, pix_if.pix_sof, pix_if.pix_eol}, e);
                    end
                    xfer_cnt++;
                    if (pix_if.pix_eol) eol_cnt++;
                end
                prev_stall = pix_if.pix_valid && !pix_if.pix_ready;
                prev_out   = {pix_if.pix_data, pix_if.pix_sof, pix_if.pix_eol};
                prev_ceb   = fb_ceb;
                prev_xfer  = pix_if.pix_valid && pix_if.pix_ready;
            end
        end
    endtask

    task automatic run_frame(input bit rnd, input bit inv, input bit poke);
        int lat;
        int cyc;
        rdy_rand = rnd;
        exp_q.delete();
        push_frame(inv);
        xfer_cnt = 0; eol_cnt = 0; rd_cnt = 0; done_cnt = 0; exp_addr = 0;
        prev_stall = 1'b0; prev_ceb = 1'b0; prev_xfer = 1'b0;
        mon_en = 1'b1;
`ifdef FB_SCANOUT_INVERT_EN
        invert = inv;
`endif
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_on_start", busy, 1);
        lat = 0;
        while (!pix_if.pix_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("first_valid_latency", lat, 3);
        if (poke) begin
            cyc = 0;
            while (xfer_cnt < 5000 && cyc < 20000) begin
                @(negedge clk);
                cyc++;
            end
            check("reached_pixel_5000", xfer_cnt >= 5000, 1);
            start = 1'b1;
`ifdef FB_SCANOUT_INVERT_EN
            invert = ~inv;
`endif
            @(negedge clk);
            start = 1'b0;
        end
        cyc = 0;
        while (done_cnt == 0 && cyc < 80000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (5) @(negedge clk);
        check("frame_done_pulses", done_cnt, 1);
        check("frame_xfers", xfer_cnt, NPix);
        check("frame_eols", eol_cnt, V_LINES);
        check("frame_reads", rd_cnt, TOTAL_BYTES);
        check("busy_after_frame", busy, 0);
        mon_en = 1'b0;
    endtask

    initial begin
        int cyc;
        int d0;
        for (int i = 0; i < TOTAL_BYTES; i++) mem[i] = DATA_W'($urandom);
        mem[0] = 8'hA5;
        mem[1] = 8'h3C;
        fork
            monitor();
        join_none

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs",
              {pix_if.pix_valid, pix_if.pix_sof, pix_if.pix_eol, busy, frame_done, fb_ceb},
              6'b0);
        check("rst_oceb", fb_oceb, 1);
        check("rst_wreb", fb_wreb, 0);
        check("rst_adb", fb_adb, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Full frame, ready held high, ignored start mid-frame.
        run_frame(1'b0, Inv, 1'b1);
        // Full frame under random backpressure.
        run_frame(1'b1, 1'b0, 1'b0);

        // Reset mid-stream aborts the frame.
        rdy_rand = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (300) @(negedge clk);
        d0 = done_any;
        reset = 1'b1;
        @(negedge clk);
        check("abort_state", {pix_if.pix_valid, busy, fb_ceb}, 3'b000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_done", done_any, d0);
        check("abort_idle", busy, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!fb_ceb && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("restart_ceb", fb_ceb, 1);
        check("restart_addr", fb_adb, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
